// File: rtl/regfile_writeback_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_if
// Purpose : Bundles the execute/memory-side handshakes, the decode hazard query
//           and the register-file write port of regfile_writeback.
// Modports: master - drives ALU results, load issue/response, decode read
//                    addresses; observes readies, hazards and the write port.
//           slave  - the writeback block itself (mirror of master).
// Signals : alu_valid/alu_addr/alu_data       ALU result (always accepted)
//           ld_issue_valid/addr/ready         load destination reservation
//           ld_resp_valid/data/ready          in-order load data return
//           rd_addr_0/1, hazard_0/1           decode pending-write query
//           busy_mask, pending_count          load scoreboard
//           wb_wen/wb_addr/wb_data            register-file write port
// -----------------------------------------------------------------------------
interface regfile_writeback_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          ld_issue_valid;
    logic [AW-1:0] ld_issue_addr;
    logic          ld_issue_ready;
    logic          ld_resp_valid;
    logic [DW-1:0] ld_resp_data;
    logic          ld_resp_ready;
    logic [AW-1:0] rd_addr_0;
    logic [AW-1:0] rd_addr_1;
    logic          hazard_0;
    logic          hazard_1;
    logic [31:0]   busy_mask;
    logic [CW-1:0] pending_count;
    logic          wb_wen;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_issue_valid, ld_issue_addr,
        output ld_resp_valid, ld_resp_data,
        output rd_addr_0, rd_addr_1,
        input  ld_issue_ready, ld_resp_ready,
        input  hazard_0, hazard_1, busy_mask, pending_count,
        input  wb_wen, wb_addr, wb_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_issue_valid, ld_issue_addr,
        input  ld_resp_valid, ld_resp_data,
        input  rd_addr_0, rd_addr_1,
        output ld_issue_ready, ld_resp_ready,
        output hazard_0, hazard_1, busy_mask, pending_count,
        output wb_wen, wb_addr, wb_data
    );
endinterface

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
// Purpose : Write-side front end of the 32x32 register file. Merges single-cycle
//           ALU results and in-order, variable-latency load returns onto the
//           single register-file write port, keeps an in-order FIFO of
//           outstanding load destinations and exports a pending-write
//           scoreboard for decode stall logic.
// Ports   : clk     - rising-edge clock
//           reset_n - asynchronous active-low reset (clears FIFO and write port)
//           bus     - regfile_writeback_if.slave (see interface header)
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_writeback_if.slave    bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_addr [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_wb_wen;
    logic [AW-1:0] r_wb_addr;
    logic [DW-1:0] r_wb_data;

    logic          w_issue_ready;
    logic          w_resp_ready;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_busy;
    logic [AW-1:0] w_head_addr;

    // Handshake decode: ALU always wins the write port, so a load response is
    // only taken on cycles without an ALU result.
    always_comb begin
        w_issue_ready = (r_count != CW'(DEPTH));
        w_resp_ready  = (r_count != {CW{1'b0}}) && !bus.alu_valid;
        w_push        = bus.ld_issue_valid && w_issue_ready;
        w_pop         = bus.ld_resp_valid && w_resp_ready;
        w_head_addr   = r_addr[r_head];
    end

    // Scoreboard: OR of one-hot destinations over the live window head..head+count-1.
    // Duplicate destinations keep their bit set until the last one pops.
    always_comb begin
        logic [PW-1:0] w_off;
        w_busy = 32'd0;
        w_off  = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_head;
            if ((CW'(w_off) < r_count) && (r_addr[i] != {AW{1'b0}})) begin
                w_busy = w_busy | (32'd1 << r_addr[i]);
            end else begin
                w_busy = w_busy;
            end
        end
    end

    // Load-destination FIFO: tail write on push, head advance on pop, occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= {AW{1'b0}};
            end
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= bus.ld_issue_addr;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered write port. Writes to r0 consume their event but never
    // assert wen; with no event, address and data hold their last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_wen  <= 1'b0;
            r_wb_addr <= {AW{1'b0}};
            r_wb_data <= {DW{1'b0}};
        end else if (bus.alu_valid) begin
            r_wb_wen  <= (bus.alu_addr != {AW{1'b0}});
            r_wb_addr <= bus.alu_addr;
            r_wb_data <= bus.alu_data;
        end else if (w_pop) begin
            r_wb_wen  <= (w_head_addr != {AW{1'b0}});
            r_wb_addr <= w_head_addr;
            r_wb_data <= bus.ld_resp_data;
        end else begin
            r_wb_wen  <= 1'b0;
        end
    end

    // Decode hazard: pending load, or the write currently on the port (the
    // regfile has not committed it yet).
    always_comb begin
        bus.hazard_0 = (bus.rd_addr_0 != {AW{1'b0}}) &&
                       (w_busy[bus.rd_addr_0] || (r_wb_wen && (r_wb_addr == bus.rd_addr_0)));
        bus.hazard_1 = (bus.rd_addr_1 != {AW{1'b0}}) &&
                       (w_busy[bus.rd_addr_1] || (r_wb_wen && (r_wb_addr == bus.rd_addr_1)));
    end

    assign bus.ld_issue_ready = w_issue_ready;
    assign bus.ld_resp_ready  = w_resp_ready;
    assign bus.busy_mask      = w_busy;
    assign bus.pending_count  = r_count;
    assign bus.wb_wen         = r_wb_wen;
    assign bus.wb_addr        = r_wb_addr;
    assign bus.wb_data        = r_wb_data;
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    regfile_writeback_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    regfile_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.alu_valid      = 1'b0;
        bus.alu_addr       = 5'd0;
        bus.alu_data       = 32'd0;
        bus.ld_issue_valid = 1'b0;
        bus.ld_issue_addr  = 5'd0;
        bus.ld_resp_valid  = 1'b0;
        bus.ld_resp_data   = 32'd0;
        bus.rd_addr_0      = 5'd0;
        bus.rd_addr_1      = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.wb_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b exp 0", bus.wb_wen); end
        checks++; if (bus.wb_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", bus.wb_addr); end
        checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.wb_data); end
        checks++; if (bus.pending_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.pending_count); end
        checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 0", bus.busy_mask); end
        checks++; if (bus.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %0b exp 1", bus.ld_issue_ready); end
        checks++; if (bus.ld_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready got %0b exp 0", bus.ld_resp_ready); end
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'hDEADBEEF;
        @(negedge clk);
        idle();
        checks++; if (bus.wb_wen !== 1'b1) begin errors++; $display("FAIL alu_wen got %0b exp 1", bus.wb_wen); end
        checks++; if (bus.wb_addr !== 5'd3) begin errors++; $display("FAIL alu_addr got %0d exp 3", bus.wb_addr); end
        checks++; if (bus.wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data got %h exp deadbeef", bus.wb_data); end
        @(negedge clk);
        checks++; if (bus.wb_wen !== 1'b0) begin errors++; $display("FAIL alu_wen_next got %0b exp 0", bus.wb_wen); end
        checks++; if (bus.wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data_hold got %h exp deadbeef", bus.wb_data); end
    endtask

    task automatic test_load_fifo();
        logic [4:0]  ia [4] = '{5'd5, 5'd6, 5'd5, 5'd7};
        logic [31:0] rd [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [31:0] bm [4] = '{32'hE0, 32'hA0, 32'h80, 32'h0};
        for (int i = 0; i < 4; i++) begin
            bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = ia[i];
            @(negedge clk);
            checks++; if (bus.pending_count !== 3'(i + 1)) begin errors++; $display("FAIL fifo_count got %0d exp %0d", bus.pending_count, i + 1); end
        end
        bus.ld_issue_addr = 5'd9;
        #1;
        checks++; if (bus.ld_issue_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got %0b exp 0", bus.ld_issue_ready); end
        @(negedge clk);
        bus.ld_issue_valid = 1'b0;
        checks++; if (bus.pending_count !== 3'd4) begin errors++; $display("FAIL fifo_full_count got %0d exp 4", bus.pending_count); end
        checks++; if (bus.busy_mask !== 32'hE0) begin errors++; $display("FAIL fifo_busy got %h exp e0", bus.busy_mask); end
        for (int i = 0; i < 4; i++) begin
            bus.ld_resp_valid = 1'b1; bus.ld_resp_data = rd[i];
            #1;
            checks++; if (bus.ld_resp_ready !== 1'b1) begin errors++; $display("FAIL resp_ready got %0b exp 1", bus.ld_resp_ready); end
            @(negedge clk);
            checks++; if (bus.wb_wen !== 1'b1) begin errors++; $display("FAIL pop_wen[%0d] got %0b exp 1", i, bus.wb_wen); end
            checks++; if (bus.wb_addr !== ia[i]) begin errors++; $display("FAIL pop_addr[%0d] got %0d exp %0d", i, bus.wb_addr, ia[i]); end
            checks++; if (bus.wb_data !== rd[i]) begin errors++; $display("FAIL pop_data[%0d] got %h exp %h", i, bus.wb_data, rd[i]); end
            checks++; if (bus.busy_mask !== bm[i]) begin errors++; $display("FAIL pop_busy[%0d] got %h exp %h", i, bus.busy_mask, bm[i]); end
        end
        idle();
        #1;
        checks++; if (bus.ld_resp_ready !== 1'b0) begin errors++; $display("FAIL empty_resp_ready got %0b exp 0", bus.ld_resp_ready); end
        @(negedge clk);
    endtask

    task automatic test_alu_priority();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = 5'd9;
        @(negedge clk);
        idle();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd4; bus.alu_data = 32'hA5A5A5A5;
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h99;
        #1;
        checks++; if (bus.ld_resp_ready !== 1'b0) begin errors++; $display("FAIL prio_resp_ready got %0b exp 0", bus.ld_resp_ready); end
        @(negedge clk);
        bus.alu_valid = 1'b0;
        checks++; if (bus.wb_addr !== 5'd4 || bus.wb_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL prio_alu got %0d/%h exp 4/a5a5a5a5", bus.wb_addr, bus.wb_data); end
        checks++; if (bus.pending_count !== 3'd1) begin errors++; $display("FAIL prio_count got %0d exp 1", bus.pending_count); end
        #1;
        checks++; if (bus.ld_resp_ready !== 1'b1) begin errors++; $display("FAIL prio_resp_ready2 got %0b exp 1", bus.ld_resp_ready); end
        @(negedge clk);
        idle();
        checks++; if (bus.wb_wen !== 1'b1 || bus.wb_addr !== 5'd9 || bus.wb_data !== 32'h99) begin errors++; $display("FAIL prio_load got %0b/%0d/%h exp 1/9/99", bus.wb_wen, bus.wb_addr, bus.wb_data); end
        checks++; if (bus.pending_count !== 3'd0) begin errors++; $display("FAIL prio_count2 got %0d exp 0", bus.pending_count); end
        @(negedge clk);
    endtask

    task automatic test_load_r0();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = 5'd0;
        @(negedge clk);
        idle();
        checks++; if (bus.pending_count !== 3'd1) begin errors++; $display("FAIL r0_count got %0d exp 1", bus.pending_count); end
        checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL r0_busy got %h exp 0", bus.busy_mask); end
        checks++; if (bus.hazard_0 !== 1'b0) begin errors++; $display("FAIL r0_hazard got %0b exp 0", bus.hazard_0); end
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h77;
        @(negedge clk);
        idle();
        checks++; if (bus.wb_wen !== 1'b0) begin errors++; $display("FAIL r0_wen got %0b exp 0", bus.wb_wen); end
        checks++; if (bus.pending_count !== 3'd0) begin errors++; $display("FAIL r0_pop_count got %0d exp 0", bus.pending_count); end
        checks++; if (bus.hazard_0 !== 1'b0) begin errors++; $display("FAIL r0_hazard2 got %0b exp 0", bus.hazard_0); end
        @(negedge clk);
    endtask

    task automatic test_hazard();
        bus.rd_addr_0 = 5'd8; bus.rd_addr_1 = 5'd8;
        #1;
        checks++; if (bus.hazard_0 !== 1'b0) begin errors++; $display("FAIL haz_before got %0b exp 0", bus.hazard_0); end
        bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = 5'd8;
        @(negedge clk);
        bus.ld_issue_valid = 1'b0;
        #1;
        checks++; if (bus.hazard_0 !== 1'b1) begin errors++; $display("FAIL haz_pending got %0b exp 1", bus.hazard_0); end
        checks++; if (bus.hazard_1 !== 1'b1) begin errors++; $display("FAIL haz1_pending got %0b exp 1", bus.hazard_1); end
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h88;
        @(negedge clk);
        bus.ld_resp_valid = 1'b0;
        #1;
        checks++; if (bus.busy_mask !== 32'd0) begin errors++; $display("FAIL haz_busy got %h exp 0", bus.busy_mask); end
        checks++; if (bus.hazard_0 !== 1'b1) begin errors++; $display("FAIL haz_wb_cycle got %0b exp 1", bus.hazard_0); end
        @(negedge clk);
        #1;
        checks++; if (bus.hazard_0 !== 1'b0) begin errors++; $display("FAIL haz_after got %0b exp 0", bus.hazard_0); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = 5'd10;
        @(negedge clk);
        bus.ld_issue_addr = 5'd11;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd2; bus.alu_data = 32'h1234;
        @(negedge clk);
        idle();
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h55;
        checks++; if (bus.pending_count !== 3'd2 || bus.wb_wen !== 1'b1) begin errors++; $display("FAIL mid_pre got %0d/%0b exp 2/1", bus.pending_count, bus.wb_wen); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.pending_count !== 3'd0 || bus.busy_mask !== 32'd0) begin errors++; $display("FAIL mid_fifo got %0d/%h exp 0/0", bus.pending_count, bus.busy_mask); end
        checks++; if (bus.wb_wen !== 1'b0 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin errors++; $display("FAIL mid_wb got %0b/%0d/%h exp 0/0/0", bus.wb_wen, bus.wb_addr, bus.wb_data); end
        checks++; if (bus.ld_resp_ready !== 1'b0) begin errors++; $display("FAIL mid_resp_ready got %0b exp 0", bus.ld_resp_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.pending_count !== 3'd0 || bus.wb_wen !== 1'b0) begin errors++; $display("FAIL mid_post got %0d/%0b exp 0/0", bus.pending_count, bus.wb_wen); end
        idle();
        @(negedge clk);
    endtask

    // Random traffic against a queue-based model of the write-back rules.
    task automatic test_random();
        int unsigned q[$];
        logic        m_wen;
        logic [4:0]  m_addr;
        logic [31:0] m_data;
        logic [31:0] e_busy;
        logic        e_iss_rdy, e_rsp_rdy, e_h0, e_h1;
        logic        push, pop;
        int unsigned head;
        do_reset();
        q.delete();
        m_wen = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        for (int n = 0; n < 600; n++) begin
            bus.alu_valid      = ($urandom_range(0, 3) == 0);
            bus.alu_addr       = 5'($urandom_range(0, 7));
            bus.alu_data       = $urandom;
            bus.ld_issue_valid = ($urandom_range(0, 1) == 1);
            bus.ld_issue_addr  = 5'($urandom_range(0, 7));
            bus.ld_resp_valid  = ($urandom_range(0, 1) == 1);
            bus.ld_resp_data   = $urandom;
            bus.rd_addr_0      = 5'($urandom_range(0, 7));
            bus.rd_addr_1      = 5'($urandom_range(0, 31));
            #1;
            e_busy = 32'd0;
            foreach (q[k]) if (q[k] != 0) e_busy[q[k]] = 1'b1;
            e_iss_rdy = (q.size() != DEPTH);
            e_rsp_rdy = (q.size() != 0) && !bus.alu_valid;
            e_h0 = (bus.rd_addr_0 != 0) && (e_busy[bus.rd_addr_0] || (m_wen && m_addr == bus.rd_addr_0));
            e_h1 = (bus.rd_addr_1 != 0) && (e_busy[bus.rd_addr_1] || (m_wen && m_addr == bus.rd_addr_1));
            checks++; if (bus.busy_mask !== e_busy) begin errors++; $display("FAIL rnd_busy[%0d] got %h exp %h", n, bus.busy_mask, e_busy); end
            checks++; if (bus.pending_count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", n, bus.pending_count, q.size()); end
            checks++; if (bus.ld_issue_ready !== e_iss_rdy || bus.ld_resp_ready !== e_rsp_rdy) begin errors++; $display("FAIL rnd_ready[%0d] got %0b%0b exp %0b%0b", n, bus.ld_issue_ready, bus.ld_resp_ready, e_iss_rdy, e_rsp_rdy); end
            checks++; if (bus.hazard_0 !== e_h0 || bus.hazard_1 !== e_h1) begin errors++; $display("FAIL rnd_hazard[%0d] got %0b%0b exp %0b%0b", n, bus.hazard_0, bus.hazard_1, e_h0, e_h1); end
            push = bus.ld_issue_valid && e_iss_rdy;
            pop  = bus.ld_resp_valid && e_rsp_rdy;
            @(negedge clk);
            if (bus.alu_valid) begin
                m_wen = (bus.alu_addr != 0); m_addr = bus.alu_addr; m_data = bus.alu_data;
            end else if (pop) begin
                head = q[0];
                m_wen = (head != 0); m_addr = 5'(head); m_data = bus.ld_resp_data;
            end else begin
                m_wen = 1'b0;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back(int'(bus.ld_issue_addr));
            checks++; if (bus.wb_wen !== m_wen) begin errors++; $display("FAIL rnd_wen[%0d] got %0b exp %0b", n, bus.wb_wen, m_wen); end
            if (m_wen) begin
                checks++; if (bus.wb_addr !== m_addr || bus.wb_data !== m_data) begin errors++; $display("FAIL rnd_wb[%0d] got %0d/%h exp %0d/%h", n, bus.wb_addr, bus.wb_data, m_addr, m_data); end
            end
        end
        idle();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle();
        test_reset();
        test_alu_write();
        test_load_fifo();
        test_alu_priority();
        test_load_r0();
        test_hazard();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
